// File: rtl/tdp_ram_param.sv
// Parametrised single-clock true-dual-port RAM with per-port enables, selectable
// write mode, optional output register, read-valid tracking and collision flag.
module tdp_ram_param #(
  parameter int DATA_WIDTH = 100,
  parameter int DEPTH      = 12,
  parameter int ADDR_WIDTH = 4,
  parameter int OUT_REG    = 0,
  parameter int WRITE_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid,
  output logic                  collision
);

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  logic                  a_in_range, b_in_range;
  logic [ADDR_WIDTH-1:0] a_idx, b_idx;
  logic [DATA_WIDTH-1:0] a_old_word, b_old_word;
  logic                  a_wr, b_wr_req, b_wr, same_addr;

  logic [DATA_WIDTH-1:0] a_s1_data_d, a_s1_data_q, b_s1_data_d, b_s1_data_q;
  logic                  a_s1_valid_d, a_s1_valid_q, b_s1_valid_d, b_s1_valid_q;
  logic [DATA_WIDTH-1:0] a_s2_data_d, a_s2_data_q, b_s2_data_d, b_s2_data_q;
  logic                  a_s2_valid_d, a_s2_valid_q, b_s2_valid_d, b_s2_valid_q;
  logic                  collision_d, collision_q;

  // A full-size array has no unused addresses, so the range check folds away.
  generate
    if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full
      assign a_in_range = 1'b1;
      assign b_in_range = 1'b1;
    end else begin : g_partial
      assign a_in_range = ({1'b0, a_addr} < DEPTH_EXT);
      assign b_in_range = ({1'b0, b_addr} < DEPTH_EXT);
    end
  endgenerate

  always_comb begin
    a_idx      = a_in_range ? a_addr : '0;
    b_idx      = b_in_range ? b_addr : '0;
    a_old_word = a_in_range ? mem_array[a_idx] : '0;
    b_old_word = b_in_range ? mem_array[b_idx] : '0;
  end

  // Port A wins a same-address write; port B's write is dropped and flagged.
  always_comb begin
    a_wr        = a_en & a_we & a_in_range;
    b_wr_req    = b_en & b_we & b_in_range;
    same_addr   = (a_addr == b_addr);
    b_wr        = b_wr_req & ~(a_wr & same_addr);
    collision_d = a_wr & b_wr_req & same_addr;
  end

  always_ff @(posedge clk) begin
    if (a_wr) begin
      mem_array[a_idx] <= a_din;
    end
    if (b_wr) begin
      mem_array[b_idx] <= b_din;
    end
  end

  always_comb begin
    a_s1_data_d  = a_s1_data_q;
    a_s1_valid_d = 1'b0;
    if (a_en) begin
      if (!a_we) begin
        a_s1_data_d  = a_old_word;
        a_s1_valid_d = 1'b1;
      end else if (WRITE_MODE == 0) begin
        a_s1_data_d  = a_old_word;
        a_s1_valid_d = 1'b1;
      end else if (WRITE_MODE == 1) begin
        a_s1_data_d  = a_din;
        a_s1_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    b_s1_data_d  = b_s1_data_q;
    b_s1_valid_d = 1'b0;
    if (b_en) begin
      if (!b_we) begin
        b_s1_data_d  = b_old_word;
        b_s1_valid_d = 1'b1;
      end else if (WRITE_MODE == 0) begin
        b_s1_data_d  = b_old_word;
        b_s1_valid_d = 1'b1;
      end else if (WRITE_MODE == 1) begin
        b_s1_data_d  = b_din;
        b_s1_valid_d = 1'b1;
      end
    end
  end

  // Second stage only captures fresh results so dout holds between accesses.
  always_comb begin
    a_s2_data_d  = a_s1_valid_q ? a_s1_data_q : a_s2_data_q;
    a_s2_valid_d = a_s1_valid_q;
    b_s2_data_d  = b_s1_valid_q ? b_s1_data_q : b_s2_data_q;
    b_s2_valid_d = b_s1_valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s1_data_q  <= '0;
      a_s1_valid_q <= 1'b0;
      b_s1_data_q  <= '0;
      b_s1_valid_q <= 1'b0;
      a_s2_data_q  <= '0;
      a_s2_valid_q <= 1'b0;
      b_s2_data_q  <= '0;
      b_s2_valid_q <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      a_s1_data_q  <= a_s1_data_d;
      a_s1_valid_q <= a_s1_valid_d;
      b_s1_data_q  <= b_s1_data_d;
      b_s1_valid_q <= b_s1_valid_d;
      a_s2_data_q  <= a_s2_data_d;
      a_s2_valid_q <= a_s2_valid_d;
      b_s2_data_q  <= b_s2_data_d;
      b_s2_valid_q <= b_s2_valid_d;
      collision_q  <= collision_d;
    end
  end

  assign a_dout    = (OUT_REG != 0) ? a_s2_data_q  : a_s1_data_q;
  assign a_valid   = (OUT_REG != 0) ? a_s2_valid_q : a_s1_valid_q;
  assign b_dout    = (OUT_REG != 0) ? b_s2_data_q  : b_s1_data_q;
  assign b_valid   = (OUT_REG != 0) ? b_s2_valid_q : b_s1_valid_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_tdp_ram_param.sv
// Scoreboard bench for tdp_ram_param: three instances (READ_FIRST/OUT_REG=0,
// WRITE_FIRST/OUT_REG=1, NO_CHANGE/OUT_REG=0) share one stimulus stream.
module tb_tdp_ram_param;
  localparam int DW = 100;
  localparam int D  = 12;
  localparam int AW = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_din = '0, b_din = '0;

  logic [DW-1:0] dout_a [3];
  logic [DW-1:0] dout_b [3];
  logic          va [3];
  logic          vb [3];
  logic          coll [3];

  int ork  [3] = '{0, 1, 0};
  int mode [3] = '{0, 1, 2};

  exp_t          q [6][$];
  int            cq [3][$];
  logic [DW-1:0] last [6];
  logic [DW-1:0] model [D];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  tdp_ram_param #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .OUT_REG(0), .WRITE_MODE(0)) u_rf (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(dout_a[0]), .a_valid(va[0]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(dout_b[0]), .b_valid(vb[0]),
    .collision(coll[0]));

  tdp_ram_param #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .OUT_REG(1), .WRITE_MODE(1)) u_wf (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(dout_a[1]), .a_valid(va[1]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(dout_b[1]), .b_valid(vb[1]),
    .collision(coll[1]));

  tdp_ram_param #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .OUT_REG(0), .WRITE_MODE(2)) u_nc (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(dout_a[2]), .a_valid(va[2]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(dout_b[2]), .b_valid(vb[2]),
    .collision(coll[2]));

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected results are derived from the bench's own copy of the array.
  task automatic applyStimulus(input logic ae, input logic awe, input logic [AW-1:0] aad,
                               input logic [DW-1:0] adi, input logic be, input logic bwe,
                               input logic [AW-1:0] bad, input logic [DW-1:0] bdi);
    int            acc;
    logic          ainr, binr, awr, bwr, c;
    logic [DW-1:0] rda, rdb;
    exp_t          e;
    @(negedge clk);
    a_en = ae; a_we = awe; a_addr = aad; a_din = adi;
    b_en = be; b_we = bwe; b_addr = bad; b_din = bdi;
    acc  = cyc + 1;
    ainr = (int'(aad) < D);
    binr = (int'(bad) < D);
    rda  = '0;
    rdb  = '0;
    if (ainr) rda = model[aad];
    if (binr) rdb = model[bad];
    for (int k = 0; k < 3; k++) begin
      e.cyc = acc + ork[k];
      if (ae && (!awe || mode[k] != 2)) begin
        e.data = (awe && mode[k] == 1) ? adi : rda;
        q[k*2].push_back(e);
      end
      if (be && (!bwe || mode[k] != 2)) begin
        e.data = (bwe && mode[k] == 1) ? bdi : rdb;
        q[k*2+1].push_back(e);
      end
    end
    awr = ae && awe && ainr;
    bwr = be && bwe && binr;
    c   = awr && bwr && (aad == bad);
    if (c) for (int k = 0; k < 3; k++) cq[k].push_back(acc);
    if (awr) model[aad] = adi;
    if (bwr && !c) model[bad] = bdi;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, 0, 0, 0, '0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    a_en = 1'b0; b_en = 1'b0; a_we = 1'b0; b_we = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst a_valid i%0d", k), va[k], '0);
      checkOutput($sformatf("rst b_valid i%0d", k), vb[k], '0);
      checkOutput($sformatf("rst a_dout i%0d", k), dout_a[k], '0);
      checkOutput($sformatf("rst b_dout i%0d", k), dout_b[k], '0);
      checkOutput($sformatf("rst collision i%0d", k), coll[k], '0);
      cq[k].delete();
    end
    for (int s = 0; s < 6; s++) begin
      q[s].delete();
      last[s] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  exp_t          mon_e;
  logic          mon_ev, mon_v;
  logic [DW-1:0] mon_d;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        mon_v = (p == 0) ? va[k] : vb[k];
        mon_d = (p == 0) ? dout_a[k] : dout_b[k];
        while (q[k*2+p].size() > 0 && q[k*2+p][0].cyc < cyc) begin
          mon_e = q[k*2+p].pop_front();
          checkOutput($sformatf("stale result i%0d p%0d", k, p), DW'(mon_e.cyc), DW'(cyc));
        end
        mon_ev = (q[k*2+p].size() > 0) && (q[k*2+p][0].cyc == cyc);
        checkOutput($sformatf("valid i%0d p%0d", k, p), mon_v, mon_ev);
        if (mon_ev) begin
          mon_e = q[k*2+p].pop_front();
          last[k*2+p] = mon_e.data;
        end
        checkOutput($sformatf("dout i%0d p%0d", k, p), mon_d, last[k*2+p]);
      end
      mon_ev = (cq[k].size() > 0) && (cq[k][0] == cyc);
      if (mon_ev) void'(cq[k].pop_front());
      checkOutput($sformatf("collision i%0d", k), coll[k], mon_ev);
    end
  end

  initial begin
    for (int i = 0; i < D; i++) model[i] = 'x;
    for (int s = 0; s < 6; s++) last[s] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Fill every word with its address, two words per cycle.
    for (int i = 0; i < D; i += 2)
      applyStimulus(1, 1, AW'(i), DW'(i), 1, 1, AW'(i + 1), DW'(i + 1));
    idle(2);

    applyStimulus(1, 1, 4'd3, 100'hABC, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, '0, 1, 0, 4'd3, '0);
    idle(2);

    applyStimulus(1, 1, 4'd5, 100'h1, 0, 0, 0, '0);
    applyStimulus(1, 1, 4'd5, 100'h2, 1, 0, 4'd5, '0);
    applyStimulus(0, 0, 0, '0, 1, 0, 4'd5, '0);
    idle(2);

    applyStimulus(1, 1, 4'd4, 100'h7, 1, 1, 4'd4, 100'h9);
    applyStimulus(1, 0, 4'd4, '0, 1, 0, 4'd4, '0);
    idle(2);

    applyStimulus(1, 1, 4'd13, 100'hF, 1, 1, 4'd13, 100'h5);
    applyStimulus(1, 0, 4'd13, '0, 1, 0, 4'd15, '0);
    for (int i = 0; i < D; i += 2)
      applyStimulus(1, 0, AW'(i), '0, 1, 0, AW'(i + 1), '0);
    idle(2);

    for (int i = 0; i < D; i += 2)
      applyStimulus(1, 1, AW'(i), DW'(i), 1, 1, AW'(i + 1), DW'(i + 1));
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, AW'(i), '0, 1, 0, AW'(i + 6), '0);
    pulseReset();
    idle(4);
    applyStimulus(1, 0, 4'd7, '0, 1, 0, 4'd7, '0);
    idle(3);

    for (int i = 0; i < 10000; i++)
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 15)),
                    DW'({$urandom, $urandom, $urandom, $urandom}),
                    $urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 15)),
                    DW'({$urandom, $urandom, $urandom, $urandom}));
    idle(4);

    @(posedge clk);
    #1;
    for (int s = 0; s < 6; s++) checkOutput($sformatf("drain s%0d", s), DW'(q[s].size()), '0);
    for (int k = 0; k < 3; k++) checkOutput($sformatf("drain coll i%0d", k), DW'(cq[k].size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
